// File: rtl/tiny5_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// tiny5_mem_responder_pkg
// Shared definitions for the tiny5 memory responder: RISC-V load/store funct3
// encodings, the responder FSM state type and the captured request record.
// No ports (package).
// -----------------------------------------------------------------------------
package tiny5_mem_responder_pkg;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } funct3_load_t;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } funct3_store_t;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_BUSY,
        MEM_RESP
    } mem_resp_state_t;

    // One request as seen on the request channel. funct3 stays raw so that
    // illegal encodings can still be captured and reported as errors.
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  funct3;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/tiny5_mem_align.sv
// -----------------------------------------------------------------------------
// tiny5_mem_align
// Combinational lane logic for the memory responder. Loads: select the byte or
// halfword addressed by addr_lo_i from the stored word and sign/zero-extend it.
// Stores: build the byte-lane write strobe and replicate the store data so each
// enabled lane sees the right byte. Also flags halfword/word misalignment.
//   funct3_i     in  3  : load/store funct3 (size in [1:0], unsigned in [2])
//   addr_lo_i    in  2  : byte offset within the word
//   wdata_i      in  32 : store data, right-aligned
//   rword_i      in  32 : word currently stored at the addressed location
//   wstrb_o      out 4  : byte-lane write strobe
//   wdata_o      out 32 : store data replicated onto the lanes
//   rdata_o      out 32 : extended load data
//   misaligned_o out 1  : halfword on odd address or word not 4-aligned
// -----------------------------------------------------------------------------
module tiny5_mem_align
    import tiny5_mem_responder_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        is_unsigned;

    assign byte_sel    = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel    = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    assign is_unsigned = funct3_i[2];

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        wstrb_o      = 4'b0000;
        wdata_o      = wdata_i;
        rdata_o      = 32'h0;
        misaligned_o = 1'b0;
        case (funct3_i[1:0])
            2'b00: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = is_unsigned ? {24'h0, byte_sel}
                                      : {{24{byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                wstrb_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{wdata_i[15:0]}};
                rdata_o      = is_unsigned ? {16'h0, half_sel}
                                           : {{16{half_sel[15]}}, half_sel};
                misaligned_o = addr_lo_i[0];
            end
            2'b10: begin
                wstrb_o      = 4'b1111;
                rdata_o      = rword_i;
                misaligned_o = |addr_lo_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tiny5_mem_responder.sv
// -----------------------------------------------------------------------------
// tiny5_mem_responder
// Memory-side responder for the tiny5 core. Accepts one load/store at a time
// over valid/ready, performs the byte/half/word access on an internal word
// array after a fixed LATENCY, and returns extended load data or a store ack.
//   clk          in  1  : clock, all state on rising edge
//   reset_n      in  1  : asynchronous active-low reset
//   req_valid    in  1  : request present
//   req_ready    out 1  : responder idle and able to accept
//   req_write    in  1  : 1 = store, 0 = load
//   req_addr     in  32 : byte address (wraps modulo 2^ADDR_WIDTH)
//   req_funct3   in  3  : RISC-V load/store funct3
//   req_wdata    in  32 : store data, right-aligned
//   resp_valid   out 1  : response present
//   resp_ready   in  1  : core consumes response
//   resp_rdata   out 32 : extended load data, 0 for stores and errors
//   resp_error   out 1  : misaligned access or illegal funct3
// -----------------------------------------------------------------------------
module tiny5_mem_responder
    import tiny5_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
    // The counter only ever holds LATENCY-2 down to 0.
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    mem_resp_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_req_t         req_q, req_live, acc_req;
    logic [31:0]      rdata_q, rdata_d;
    logic             error_q, error_d;
    logic [31:0]      mem_q [DEPTH];

    logic                  accept, access, illegal, misaligned, acc_err, mem_we;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [3:0]            wstrb;
    logic [31:0]           wdata_lanes, rdata_ext, rword;
    logic                  unused_addr_hi;

    assign req_ready  = (state_q == MEM_IDLE);
    assign resp_valid = (state_q == MEM_RESP);
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;

    assign accept   = req_valid && req_ready;
    assign req_live = '{write: req_write, addr: req_addr, funct3: req_funct3, wdata: req_wdata};

    // With LATENCY == 1 the access happens on the accept edge itself, so the
    // live request is used; otherwise the captured copy drives the access.
    assign acc_req = (state_q == MEM_IDLE) ? req_live : req_q;

    assign word_idx       = acc_req.addr[ADDR_WIDTH-1:2];
    assign rword          = mem_q[word_idx];
    assign unused_addr_hi = ^acc_req.addr[31:ADDR_WIDTH];

    tiny5_mem_align u_align (
        .funct3_i     (acc_req.funct3),
        .addr_lo_i    (acc_req.addr[1:0]),
        .wdata_i      (acc_req.wdata),
        .rword_i      (rword),
        .wstrb_o      (wstrb),
        .wdata_o      (wdata_lanes),
        .rdata_o      (rdata_ext),
        .misaligned_o (misaligned)
    );

    assign illegal = acc_req.write ? !(acc_req.funct3 inside {F3_SB, F3_SH, F3_SW})
                                   : !(acc_req.funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    assign acc_err = illegal || misaligned;

    // reset_n gating keeps a LATENCY == 1 request presented during reset from
    // writing the array, which itself has no reset.
    assign mem_we = access && acc_req.write && !acc_err && reset_n;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = MEM_RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = MEM_BUSY;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            MEM_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MEM_RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            MEM_RESP: begin
                if (resp_ready) state_d = MEM_IDLE;
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        error_d = error_q;
        if (access) begin
            error_d = acc_err;
            rdata_d = (acc_err || acc_req.write) ? 32'h0 : rdata_ext;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            error_q <= 1'b0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            if (accept) req_q <= req_live;
        end
    end

    // NOTE: the word array is deliberately left out of reset so it maps onto
    // RAM with per-byte write enables; contents survive reset.
    always_ff @(posedge clk) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (mem_we && wstrb[lane]) begin
                mem_q[word_idx][8*lane +: 8] <= wdata_lanes[8*lane +: 8];
            end
        end
    end

endmodule

// File: doc/tiny5_mem_responder.md
# tiny5_mem_responder

Memory-side responder for the tiny5 core's data/instruction memory port. It accepts read and write requests over a valid/ready handshake and performs byte, halfword or word accesses on an internal word array, using the RISC-V load/store funct3 encodings. It returns sign- or zero-extended read data, or a write acknowledge, after a fixed programmable latency. It sits between the core's memory address mux and the on-chip RAM, and serves as the bench memory model for the core.

## Interface
- `ADDR_WIDTH`, default 12: byte-address bits decoded; depth = 2^(ADDR_WIDTH-2) words; upper address bits ignored (wrap modulo depth).
- `LATENCY`, default 2: cycles from request accept to `resp_valid`; legal range ≥1.

Ports:
- `clk` — in, 1: single clock; all state on rising edge.
- `reset_n` — in, 1: asynchronous, active-low reset.
- `req_valid` — in, 1: request present.
- `req_ready` — out, 1: responder can accept.
- `req_write` — in, 1: 1 = store, 0 = load.
- `req_addr` — in, 32: byte address.
- `req_funct3` — in, 3: `funct3_load_t` when loading, `funct3_store_t` when storing.
- `req_wdata` — in, 32: store data, right-aligned in the low bits.
- `resp_valid` — out, 1: response present.
- `resp_ready` — in, 1: core consumes response.
- `resp_rdata` — out, 32: extended load data; 0 for stores and errors.
- `resp_error` — out, 1: misaligned access or illegal funct3.

## Operation
- FSM states: IDLE, BUSY, RESP.
  - `req_ready` = (state == IDLE).
  - `resp_valid` = (state == RESP).
- **IDLE:** on `req_valid && req_ready`, capture `req_write`, `req_addr`, `req_funct3` and `req_wdata`.
  - If LATENCY == 1, go to RESP.
  - Otherwise load the counter with LATENCY-2 and go to BUSY.
- **BUSY:** decrement the counter each cycle. At 0, perform the access and go to RESP.
- **Access** happens on the edge entering RESP.
  - Loads register `resp_rdata`.
  - Stores update the selected byte lanes only.
- **RESP:** hold `resp_valid`, `resp_rdata` and `resp_error` stable until `resp_ready`, then return to IDLE. A new request can be accepted no earlier than the following cycle.
- **Load extension:**
  - LB/LBU select byte `addr[1:0]`, sign/zero-extended to 32 bits.
  - LH/LHU select half `addr[1]`, sign/zero-extended to 32 bits.
  - LW returns the whole word.
- **Store lanes:**
  - SB writes `wdata[7:0]` to lane `addr[1:0]`.
  - SH writes `wdata[15:0]` to lanes `{addr[1],0}` and `{addr[1],1}`.
  - SW writes all four lanes.
- **Error cases:**
  - Halfword access with `addr[0]=1`.
  - Word access with `addr[1:0]≠0`.
  - Load funct3 ∈ {011,110,111}.
  - Store funct3 ≥ 011.
- **On error:** `resp_error=1`, `resp_rdata=0`, no memory modification; latency is unchanged.
- **Reset (asynchronous, any state):** state IDLE, counter 0, `resp_rdata` 0, `resp_error` 0.
  - Hence `req_ready=1` and `resp_valid=0` during and after reset.
  - A store not yet performed is dropped.
  - Memory contents are not reset.

## Timing
- Accept edge E. `resp_valid` rises after edge E+LATENCY-1, i.e. it is visible in the LATENCY-th cycle after the accept cycle.
- Minimum request-to-request spacing: LATENCY+1 cycles when `resp_ready` is held high.
- `req_ready` is low from the accept edge until the edge after response handshake.
- A `req_valid` asserted during BUSY/RESP is not accepted and must be held by the core.
- Inputs are only sampled at the accept edge; later changes on `req_*` have no effect.
- No combinational path from `req_*` to `resp_*`. `req_ready` depends on state only.

## Structure
- Shared `definitions` package additions:
  - `mem_resp_state_t` enum {MEM_IDLE, MEM_BUSY, MEM_RESP}.
  - Reuse `funct3_load_t` and `funct3_store_t`.
- Sub-module `tiny5_mem_align`: combinational lane select/extend for loads, and byte-enable plus data replication for stores. Its outputs are the 4-bit write strobe, the shifted write data, the extended read data and the misalignment flag.
- Top module holds the FSM, latency counter, request capture registers and the word array. The word array is inferred RAM with per-byte write enable.

## Test plan
- **Word round trip, LATENCY=2:** SW `addr 0x10`, data `0xDEADBEEF`, then LW `0x10`.
  - Expect `rdata 0xDEADBEEF`, `error 0`.
  - `resp_valid` appears 2 cycles after each accept.
- **Byte/half extension:** after the word above, expect:
  - LB `0x13` → `0xFFFFFFDE`.
  - LBU `0x13` → `0x000000DE`.
  - LH `0x10` → `0xFFFFBEEF`.
  - LHU `0x12` → `0x0000DEAD`.
- **Partial store:** SB `0x11` with `0x55`, then LW `0x10` → `0xDEAD55EF`.
- **Errors:** each of the following returns `error=1`, `rdata 0`, with memory unchanged on a subsequent LW `0x10`:
  - LW `0x12`.
  - SH `0x11`.
  - Load funct3 `3'b011`.
- **Backpressure:** hold `resp_ready=0` for 5 cycles during a LW.
  - `resp_valid`/`rdata` stay stable and `req_ready` stays 0.
  - A pending `req_valid` is accepted only the cycle after `resp_ready`.
- **Reset mid-operation, LATENCY=4:**
  - Assert `reset_n=0` in the BUSY cycle of SW `0x20` with `0x12345678`.
  - Expect `req_ready=1` and `resp_valid=0` immediately.
  - A subsequent LW `0x20` returns the pre-existing contents, not `0x12345678`.
  - With LATENCY=1, the response arrives 1 cycle after accept.
